// File: rtl/bfp_normalizer_pkg.sv
// Shared definitions for the FFT front end: default sample/frame sizing and
// the two-state encoding used by the block-floating-point normalizer.
package bfp_normalizer_pkg;

  localparam int BFP_N          = 3;
  localparam int BFP_W          = 2 ** BFP_N;
  localparam int BFP_FRAME_LOG2 = 3;
  localparam int BFP_F          = 2 ** BFP_FRAME_LOG2;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } bfp_state_e;

endpackage

// File: rtl/bfp_normalizer_headroom_cnt.sv
// Leading-sign-bit counter: number of redundant sign bits below the MSB,
// so 0 and -1 both report W-1.
module headroom_cnt #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] x_i,
  output logic [N-1:0]    h_o
);

  localparam int W = 2 ** N;

  logic [N-1:0] cnt;
  logic         run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = W - 2; i >= 0; i--) begin
      if (run && (x_i[i] == x_i[W-1])) begin
        cnt = cnt + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    h_o = cnt;
  end

endmodule

// File: rtl/bfp_normalizer.sv
// Block-floating-point normalizer: buffers one frame, finds the smallest
// headroom across it, then replays the frame shifted left by that amount.
module bfp_normalizer
  import bfp_normalizer_pkg::*;
#(
  parameter int N          = BFP_N,
  parameter int FRAME_LOG2 = BFP_FRAME_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   out_data,
  output logic [N-1:0]      out_exp,
  output logic              out_last
);

  localparam int W = 2 ** N;
  localparam int F = 2 ** FRAME_LOG2;
  localparam logic [FRAME_LOG2-1:0] LAST = '1;
  localparam logic [N-1:0]          HMAX = '1;

  function automatic logic [W-1:0] ashl(input logic signed [W-1:0] x,
                                        input logic [N-1:0] e);
    return x <<< e;
  endfunction

  bfp_state_e              state_q;
  logic [FRAME_LOG2-1:0]   idx_q;
  logic [FRAME_LOG2-1:0]   rd_q;
  logic [N-1:0]            min_q;
  logic [N-1:0]            exp_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic signed [W-1:0]     out_data_q;
  logic                    out_last_q;
  logic signed [W-1:0]     mem_q [F];

  logic [N-1:0]            h_in;
  logic [N-1:0]            min_d;
  logic [FRAME_LOG2-1:0]   rd_d;
  logic signed [W-1:0]     first_smp;
  logic                    accept;

  headroom_cnt #(.N(N)) u_headroom (
    .x_i (in_data),
    .h_o (h_in)
  );

  assign accept    = (state_q == FILL) && in_valid;
  assign min_d     = (h_in < min_q) ? h_in : min_q;
  assign rd_d      = rd_q + 1'b1;
  // With a one-sample frame the sample being accepted is the first output.
  assign first_smp = (idx_q == '0) ? in_data : mem_q[0];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[idx_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      rd_q        <= '0;
      min_q       <= HMAX;
      exp_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid) begin
            idx_q <= idx_q + 1'b1;
            min_q <= min_d;
            if (idx_q == LAST) begin
              exp_q       <= min_d;
              state_q     <= DRAIN;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= ashl(first_smp, min_d);
              out_last_q  <= (F == 1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_q == LAST) begin
              state_q     <= FILL;
              idx_q       <= '0;
              rd_q        <= '0;
              min_q       <= HMAX;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              rd_q       <= rd_d;
              out_data_q <= ashl(mem_q[rd_d], exp_q);
              out_last_q <= (rd_d == LAST);
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_exp   = exp_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_bfp_normalizer.sv
// Directed bench for bfp_normalizer: table of frames with hand-computed
// exponents and shifted outputs, plus stall and reset sequences.
module tb_bfp_normalizer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_exp;
  logic       out_last;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [0:7][7:0] din;
    logic [2:0]      e;
    logic [0:7][7:0] dout;
  } vec_t;

  vec_t vecs [6];

  bfp_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_exp   (out_exp),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_exp", out_exp, 0);
    chk("rst_out_last", out_last, 0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state();
  endtask

  // Idle slots carry 7F (headroom 0) so a wrongly stored sample would force E=0.
  task automatic send_frame(input logic [0:7][7:0] d, input bit gaps);
    int  n   = 0;
    int  cyc = 0;
    bit  hs;
    chk("fill_in_ready", in_ready, 1);
    chk("fill_out_valid", out_valid, 0);
    while (n < 8 && cyc < 400) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? d[n] : 8'h7F;
      hs       = in_valid && in_ready;
      tick();
      cyc++;
      if (hs) n++;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    if (n < 8) chk("fill_timeout", n, 8);
    else chk("first_valid_latency", out_valid, 1);
  endtask

  task automatic recv_frame(input vec_t v, input int stall_at, input int stall_len,
                            input int n_take);
    for (int i = 0; i < n_take; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          out_ready = 1'b0;
          in_valid  = 1'b1;
          in_data   = 8'h80;
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, v.dout[i]);
          chk("stall_in_ready", in_ready, 0);
          tick();
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      chk("out_valid", out_valid, 1);
      chk($sformatf("out_data[%0d]", i), out_data, v.dout[i]);
      chk("out_exp", out_exp, v.e);
      chk($sformatf("out_last[%0d]", i), out_last, (i == 7));
      chk("drain_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b0;
    if (n_take == 8) begin
      chk("end_out_valid", out_valid, 0);
      chk("end_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // 0x10 carries only two redundant sign bits, so it bounds E at 2.
    vecs[0] = '{din: 64'h05F300FF10F007F8, e: 3'd2, dout: 64'h14CC00FC40C01CE0};
    vecs[1] = '{din: 64'h0000000000000000, e: 3'd7, dout: 64'h0000000000000000};
    vecs[2] = '{din: 64'h01FF8002FE030004, e: 3'd0, dout: 64'h01FF8002FE030004};
    vecs[3] = '{din: 64'h01FF02FE03FD0001, e: 3'd5, dout: 64'h20E040C060A00020};
    vecs[4] = '{din: 64'hFFFFFFFFFFFFFFFF, e: 3'd7, dout: 64'h8080808080808080};
    vecs[5] = '{din: 64'h3FC11FE000FF10F0, e: 3'd1, dout: 64'h7E823EC000FE20E0};

    tick();
    tick();
    check_reset_state();
    rst_n = 1'b1;
    tick();
    check_reset_state();

    for (int k = 0; k < 6; k++) begin
      send_frame(vecs[k].din, (k % 2) == 1);
      recv_frame(vecs[k], -1, 0, 8);
    end

    // Backpressure mid-drain while junk is offered on the input side.
    send_frame(vecs[0].din, 1'b1);
    recv_frame(vecs[0], 3, 5, 8);
    send_frame(vecs[3].din, 1'b0);
    recv_frame(vecs[3], -1, 0, 8);

    // Reset after four accepted headroom-0 samples; they must not leak into E.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h7F;
      tick();
    end
    do_reset();
    send_frame(vecs[3].din, 1'b0);
    recv_frame(vecs[3], -1, 0, 8);

    // Reset in the middle of a drain, then a fresh frame.
    send_frame(vecs[2].din, 1'b0);
    recv_frame(vecs[2], -1, 0, 3);
    do_reset();
    send_frame(vecs[5].din, 1'b1);
    recv_frame(vecs[5], -1, 0, 8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
